// File: rtl/xunit_m.sv
// SHA-256 message schedule unit: accepts a 16-word block after a programmable
// start delay and emits W[0..63] with the matching round constants K[0..63].
module xunit_m #(
  parameter int DELAY_W = 7,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               running,
  input  logic               run,
  output logic               done,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0,
  output logic [DATA_W-1:0]  out1,
  input  logic [DELAY_W-1:0] delay0
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  state_t             state;
  logic [DELAY_W-1:0] dly;
  logic [5:0]         t;
  // hist[0] holds W[t-1], hist[15] holds W[t-16]
  logic [31:0]        hist [16];
  logic [31:0]        w_new;

  // The accelerator-running flag carries no meaning for this unit.
  logic unused_running;
  assign unused_running = running;

  // Unit is idle exactly when the FSM rests in IDLE.
  assign done = (state == IDLE);

  // Next schedule word: message word for t<16, recurrence afterwards.
  always_comb begin
    w_new = '0;
    if (t < 6'd16) begin
      w_new = in0;
    end else begin
      w_new = sig1(hist[1]) + hist[6] + sig0(hist[14]) + hist[15];
    end
  end

  // Control FSM, delay/round counters, word history and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      dly   <= '0;
      t     <= '0;
      out0  <= '0;
      out1  <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        hist[i] <= '0;
      end
    end else if (run) begin
      dly   <= delay0;
      state <= WAIT;
      t     <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (dly == '0) begin
            state <= ACTIVE;
            t     <= '0;
          end else begin
            dly <= dly - 1'b1;
          end
        end
        ACTIVE: begin
          out0    <= w_new;
          out1    <= K_ROM[t];
          hist[0] <= w_new;
          for (int unsigned i = 1; i < 16; i++) begin
            hist[i] <= hist[i-1];
          end
          t <= t + 1'b1;
          if (t == 6'd63) begin
            state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xunit_m.sv
// Scoreboard bench for xunit_m: stimulus pushes cycle-stamped expectations
// from a plain SHA-256 schedule model; a negedge monitor checks them.
module tb_xunit_m;

  logic        clk = 1'b0;
  logic        rst;
  logic        running;
  logic        run;
  logic        done;
  logic [31:0] in0;
  logic [31:0] out0;
  logic [31:0] out1;
  logic [6:0]  delay0;

  xunit_m #(.DELAY_W(7), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .running(running), .run(run), .done(done),
    .in0(in0), .out0(out0), .out1(out1), .delay0(delay0)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    int          at;
    logic [31:0] w;
    logic [31:0] k;
    logic        d;
  } exp_t;

  typedef struct {
    int          at;
    logic [31:0] w;
    logic [31:0] k;
  } ev_t;

  exp_t sb [$];
  ev_t  evs [$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // Cycle counter: cycle n is the interval following the n-th rising edge.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: compare every expectation stamped with the current cycle.
  initial forever begin
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        total++;
        if (out0 !== sb[i].w) begin
          bad++;
          $display("FAIL out0 cyc=%0d got=%h want=%h", cyc, out0, sb[i].w);
        end
        total++;
        if (out1 !== sb[i].k) begin
          bad++;
          $display("FAIL out1 cyc=%0d got=%h want=%h", cyc, out1, sb[i].k);
        end
        total++;
        if (done !== sb[i].d) begin
          bad++;
          $display("FAIL done cyc=%0d got=%b want=%b", cyc, done, sb[i].d);
        end
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        total++;
        bad++;
        $display("FAIL missed cyc=%0d got=none want=check@%0d", cyc, sb[i].at);
        sb.delete(i);
      end
    end
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic schedule(input logic [31:0] m [16], output logic [31:0] w [64]);
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = m[i];
      else        w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drop every pending expectation and output change later than cycle n.
  task automatic flush(input int n);
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].at > n) sb.delete(i);
    for (int i = evs.size() - 1; i >= 0; i--)
      if (evs[i].at > n) evs.delete(i);
  endtask

  // Model output value in force during cycle n.
  task automatic out_at(input int n, output logic [31:0] w, output logic [31:0] k);
    int best;
    best = -1;
    w = '0;
    k = '0;
    foreach (evs[i]) begin
      if (evs[i].at <= n && evs[i].at > best) begin
        best = evs[i].at;
        w = evs[i].w;
        k = evs[i].k;
      end
    end
  endtask

  task automatic expect_at(input int at, input logic [31:0] w, input logic [31:0] k,
                           input logic d);
    exp_t e;
    e.at = at;
    e.w  = w;
    e.k  = k;
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic set_out(input int at, input logic [31:0] w, input logic [31:0] k);
    ev_t e;
    e.at = at;
    e.w  = w;
    e.k  = k;
    evs.push_back(e);
  endtask

  // Issue run in the current cycle c, feed the block, return in cycle c+stop.
  task automatic run_block(input int d, input logic [31:0] m [16], input int stop,
                           input bit abc);
    int          c;
    logic [31:0] w [64];
    logic [31:0] hw;
    logic [31:0] hk;
    c = cyc;
    flush(c);
    out_at(c, hw, hk);
    schedule(m, w);
    if (abc) begin
      w[16] = 32'h61626380;
      w[17] = 32'h000f0000;
    end
    for (int i = 1; i <= d + 2; i++) expect_at(c + i, hw, hk, 1'b0);
    for (int i = 0; i < 64; i++) begin
      expect_at(c + d + 3 + i, w[i], KT[i], (i == 63));
      set_out(c + d + 3 + i, w[i], KT[i]);
    end
    expect_at(c + d + 67, w[63], KT[63], 1'b1);
    run    = 1'b1;
    delay0 = 7'(d);
    for (int k = 1; k <= stop; k++) begin
      next_cycle();
      run     = 1'b0;
      delay0  = 7'($urandom);
      running = 1'($urandom);
      if (k >= d + 2 && k <= d + 17) in0 = m[k - d - 2];
      else                           in0 = $urandom;
    end
  endtask

  task automatic do_reset();
    int n;
    n = cyc;
    rst = 1'b0;
    flush(n);
    expect_at(n + 1, '0, '0, 1'b1);
    expect_at(n + 2, '0, '0, 1'b1);
    set_out(n + 1, '0, '0);
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic rand_block(output logic [31:0] m [16]);
    for (int i = 0; i < 16; i++) m[i] = $urandom;
  endtask

  initial begin
    logic [31:0] m  [16];
    logic [31:0] m2 [16];
    int          d;
    int          d2;

    rst     = 1'b0;
    run     = 1'b0;
    running = 1'b0;
    in0     = '0;
    delay0  = '0;
    next_cycle();
    do_reset();
    next_cycle();

    // "abc" padded block, zero delay
    for (int i = 0; i < 16; i++) m[i] = '0;
    m[0]  = 32'h61626380;
    m[15] = 32'h00000018;
    run_block(0, m, 66, 1'b1);
    repeat (3) next_cycle();

    // delay 3, random data
    rand_block(m);
    run_block(3, m, 69, 1'b0);
    repeat (2) next_cycle();

    // abort at t=30 by a new run
    rand_block(m);
    rand_block(m2);
    d  = $urandom_range(1, 6);
    d2 = $urandom_range(0, 5);
    run_block(d, m, d + 32, 1'b0);
    run_block(d2, m2, d2 + 66, 1'b0);
    repeat (2) next_cycle();

    // reset at t=20, then a fresh block
    rand_block(m);
    d = $urandom_range(0, 4);
    run_block(d, m, d + 22, 1'b0);
    do_reset();
    next_cycle();
    rand_block(m);
    run_block(d, m, d + 66, 1'b0);
    repeat (2) next_cycle();

    // back-to-back: second run on the cycle done rises
    rand_block(m);
    rand_block(m2);
    d  = $urandom_range(0, 4);
    d2 = $urandom_range(0, 4);
    run_block(d, m, d + 66, 1'b0);
    run_block(d2, m2, d2 + 66, 1'b0);
    repeat (2) next_cycle();

    // all-ones block exercises mod 2^32 wrap
    for (int i = 0; i < 16; i++) m[i] = 32'hffffffff;
    run_block(2, m, 68, 1'b0);
    repeat (2) next_cycle();

    // a few random blocks with random delays and gaps
    for (int r = 0; r < 3; r++) begin
      rand_block(m);
      d = $urandom_range(0, 20);
      run_block(d, m, d + 66, 1'b0);
      repeat ($urandom_range(1, 4)) next_cycle();
    end

    for (int i = 0; i < 300 && sb.size() != 0; i++) next_cycle();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain cyc=%0d got=%0d pending want=0", cyc, sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
